// File: rtl/flash_command_sequencer.sv
// JEDEC command sequencer for the dual 8-bit Kickstart flash pair: issues unlock/command
// write cycles, then DQ7 data-polls with a saturating timeout and reports DONE or ERROR.
module flash_command_sequencer #(
    parameter int SETUP_CLKS = 1,
    parameter int PULSE_CLKS = 2,
    parameter int HOLD_CLKS  = 1,
    parameter int RD_CLKS    = 2,
    parameter int TIMEOUT_W  = 28
) (
    input  logic        MB_CLK,
    input  logic        RESET,
    input  logic [1:0]  CMD,
    input  logic [19:0] CMD_ADDR,
    input  logic [15:0] CMD_DATA,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    output logic        DONE,
    output logic        ERROR,
    output logic [19:0] FLASH_ADDR,
    output logic [15:0] FLASH_DQ_OUT,
    output logic        FLASH_DQ_OE,
    input  logic [15:0] FLASH_DQ_IN,
    output logic [1:0]  FLASH_WR,
    output logic [1:0]  FLASH_RD
);

    typedef enum logic [3:0] {
        IDLE, W_SETUP, W_PULSE, W_HOLD, POLL_RD, POLL_GAP, ABORT, DONE_ST, ERROR_ST
    } state_t;

    localparam logic [1:0] CMD_RST = 2'b00;
    localparam logic [1:0] CMD_PGM = 2'b01;
    localparam logic [1:0] CMD_SEC = 2'b10;

    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CLKS - 1);
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CLKS - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CLKS - 1);
    localparam logic [7:0] RD_LOAD    = 8'(RD_CLKS - 1);

    state_t                 state;
    logic [1:0]             cmd_q;
    logic [19:0]            addr_q;
    logic [15:0]            data_q;
    logic [2:0]             step;
    logic [7:0]             phase_cnt;
    logic [TIMEOUT_W-1:0]   tmo_cnt;
    logic [3:0]             poll_q;
    logic                   first_poll;
    logic                   retry;
    logic                   aborting;
    logic                   exp_hi;
    logic                   exp_lo;
    logic                   poll_match;
    logic                   poll_fault;

    function automatic logic [19:0] step_addr(input logic [1:0] c, input logic [2:0] s,
                                              input logic [19:0] a);
        logic [19:0] r;
        r = 20'h00555;
        if (c == CMD_RST)
            r = 20'h00000;
        else if (s == 3'd1 || s == 3'd4)
            r = 20'h002AA;
        else if ((c == CMD_PGM && s == 3'd3) || (c == CMD_SEC && s == 3'd5))
            r = a;
        return r;
    endfunction

    function automatic logic [15:0] step_data(input logic [1:0] c, input logic [2:0] s,
                                              input logic [15:0] d);
        logic [7:0]  b;
        logic [15:0] r;
        case (s)
            3'd1, 3'd4: b = 8'h55;
            3'd2:       b = (c == CMD_PGM) ? 8'hA0 : 8'h80;
            3'd5:       b = (c == CMD_SEC) ? 8'h30 : 8'h10;
            default:    b = 8'hAA;
        endcase
        if (c == CMD_RST)
            b = 8'hF0;
        r = {b, b};
        if (c == CMD_PGM && s == 3'd3)
            r = d;
        return r;
    endfunction

    function automatic logic [2:0] last_step(input logic [1:0] c);
        logic [2:0] r;
        if (c == CMD_RST)
            r = 3'd0;
        else if (c == CMD_PGM)
            r = 3'd3;
        else
            r = 3'd5;
        return r;
    endfunction

    // Program polls for the written DQ7/DQ15 values; erases poll until both lanes read 1.
    assign exp_hi     = (cmd_q == CMD_PGM) ? data_q[15] : 1'b1;
    assign exp_lo     = (cmd_q == CMD_PGM) ? data_q[7]  : 1'b1;
    assign poll_match = (poll_q[3] == exp_hi) && (poll_q[1] == exp_lo);
    assign poll_fault = poll_q[2] | poll_q[0];

    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            cmd_q        <= 2'b00;
            addr_q       <= 20'h0;
            data_q       <= 16'h0;
            step         <= 3'd0;
            phase_cnt    <= 8'd0;
            tmo_cnt      <= '0;
            poll_q       <= 4'h0;
            first_poll   <= 1'b0;
            retry        <= 1'b0;
            aborting     <= 1'b0;
            CMD_READY    <= 1'b1;
            DONE         <= 1'b0;
            ERROR        <= 1'b0;
            FLASH_ADDR   <= 20'h0;
            FLASH_DQ_OUT <= 16'h0;
            FLASH_DQ_OE  <= 1'b0;
            FLASH_WR     <= 2'b11;
            FLASH_RD     <= 2'b11;
        end else begin
            DONE  <= 1'b0;
            ERROR <= 1'b0;
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        cmd_q        <= CMD;
                        addr_q       <= CMD_ADDR;
                        data_q       <= CMD_DATA;
                        step         <= 3'd0;
                        retry        <= 1'b0;
                        aborting     <= 1'b0;
                        FLASH_ADDR   <= step_addr(CMD, 3'd0, CMD_ADDR);
                        FLASH_DQ_OUT <= step_data(CMD, 3'd0, CMD_DATA);
                        FLASH_DQ_OE  <= 1'b1;
                        CMD_READY    <= 1'b0;
                        phase_cnt    <= SETUP_LOAD;
                        state        <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    if (phase_cnt != 8'd0) begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end else begin
                        FLASH_WR  <= 2'b00;
                        phase_cnt <= PULSE_LOAD;
                        state     <= W_PULSE;
                    end
                end
                W_PULSE: begin
                    if (phase_cnt != 8'd0) begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end else begin
                        FLASH_WR  <= 2'b11;
                        phase_cnt <= HOLD_LOAD;
                        state     <= W_HOLD;
                    end
                end
                W_HOLD: begin
                    if (phase_cnt != 8'd0) begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end else if (step != last_step(cmd_q)) begin
                        step         <= step + 3'd1;
                        FLASH_ADDR   <= step_addr(cmd_q, step + 3'd1, addr_q);
                        FLASH_DQ_OUT <= step_data(cmd_q, step + 3'd1, data_q);
                        phase_cnt    <= SETUP_LOAD;
                        state        <= W_SETUP;
                    end else begin
                        FLASH_DQ_OE <= 1'b0;
                        if (aborting) begin
                            ERROR <= 1'b1;
                            state <= ERROR_ST;
                        end else if (cmd_q == CMD_RST) begin
                            DONE  <= 1'b1;
                            state <= DONE_ST;
                        end else begin
                            // First POLL_GAP visit is the bus turnaround clock before reading.
                            first_poll <= 1'b1;
                            state      <= POLL_GAP;
                        end
                    end
                end
                POLL_RD: begin
                    if (&tmo_cnt) begin
                        FLASH_RD <= 2'b11;
                        state    <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                        if (phase_cnt != 8'd0) begin
                            phase_cnt <= phase_cnt - 8'd1;
                        end else begin
                            poll_q   <= {FLASH_DQ_IN[15], FLASH_DQ_IN[13], FLASH_DQ_IN[7], FLASH_DQ_IN[5]};
                            FLASH_RD <= 2'b11;
                            state    <= POLL_GAP;
                        end
                    end
                end
                POLL_GAP: begin
                    if (first_poll) begin
                        first_poll <= 1'b0;
                        tmo_cnt    <= '0;
                        FLASH_RD   <= 2'b00;
                        phase_cnt  <= RD_LOAD;
                        state      <= POLL_RD;
                    end else if (&tmo_cnt) begin
                        state <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                        if (poll_match) begin
                            DONE  <= 1'b1;
                            state <= DONE_ST;
                        end else if (retry) begin
                            state <= ABORT;
                        end else begin
                            retry     <= poll_fault;
                            FLASH_RD  <= 2'b00;
                            phase_cnt <= RD_LOAD;
                            state     <= POLL_RD;
                        end
                    end
                end
                ABORT: begin
                    // Reuse the write path as a single reset (F0) command, ending in ERROR.
                    aborting     <= 1'b1;
                    cmd_q        <= CMD_RST;
                    step         <= 3'd0;
                    FLASH_ADDR   <= 20'h0;
                    FLASH_DQ_OUT <= 16'hF0F0;
                    FLASH_DQ_OE  <= 1'b1;
                    phase_cnt    <= SETUP_LOAD;
                    state        <= W_SETUP;
                end
                DONE_ST, ERROR_ST: begin
                    CMD_READY <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
